// File: rtl/div_unit_if.sv
// Handshake bundle between the execute stage and the divide unit.
// The pipeline side is master; the divider is slave.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             StartE;
  logic [1:0]       DivOpE;
  logic [WIDTH-1:0] Op1E;
  logic [WIDTH-1:0] Op2E;
  logic             FlushE;
  logic             BusyE;
  logic             DoneE;
  logic [WIDTH-1:0] DivResultE;

  modport master (
    output StartE, DivOpE, Op1E, Op2E, FlushE,
    input  BusyE, DoneE, DivResultE
  );

  modport slave (
    input  StartE, DivOpE, Op1E, Op2E, FlushE,
    output BusyE, DoneE, DivResultE
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow finish without iterating.
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      reset_n,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_qneg;
  logic             r_rneg;

  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_div0;
  logic             w_ovf;
  logic             w_special;
  logic [WIDTH-1:0] w_spec_res;
  logic [WIDTH:0]   w_trial;
  logic             w_sub_ok;
  logic [WIDTH-1:0] w_fix;

  assign w_signed  = ~bus.DivOpE[0];
  assign w_a_neg   = w_signed & bus.Op1E[WIDTH-1];
  assign w_b_neg   = w_signed & bus.Op2E[WIDTH-1];
  assign w_a_abs   = w_a_neg ? -bus.Op1E : bus.Op1E;
  assign w_b_abs   = w_b_neg ? -bus.Op2E : bus.Op2E;
  assign w_div0    = (bus.Op2E == '0);
  assign w_ovf     = w_signed
                   & (bus.Op1E == {1'b1, {(WIDTH-1){1'b0}}})
                   & (&bus.Op2E);
  assign w_special = w_div0 | w_ovf;

  // Overflow quotient equals the dividend (most negative value).
  assign w_spec_res = bus.DivOpE[1]
                    ? (w_div0 ? bus.Op1E : '0)
                    : (w_div0 ? '1 : bus.Op1E);

  // Full R keeps its MSB so large unsigned divisors stay exact.
  assign w_trial  = {r_r, r_q[WIDTH-1]} - {1'b0, r_d};
  assign w_sub_ok = ~w_trial[WIDTH];

  assign w_fix = r_op[1]
               ? (r_rneg ? -r_r : r_r)
               : (r_qneg ? -r_q : r_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.FlushE) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.StartE)
                  w_next = w_special ? S_DONE : S_ITER;
        S_ITER: if (r_cnt == '0) w_next = S_FIX;
        S_FIX:  w_next = S_DONE;
        S_DONE: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op   <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_d    <= '0;
      r_res  <= '0;
      r_cnt  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else if (!bus.FlushE) begin
      unique case (r_state)
        S_IDLE: if (bus.StartE) begin
          r_op   <= bus.DivOpE;
          r_d    <= w_b_abs;
          r_q    <= w_a_abs;
          r_r    <= '0;
          r_cnt  <= CW'(WIDTH-1);
          r_qneg <= w_a_neg ^ w_b_neg;
          r_rneg <= w_a_neg;
          if (w_special) r_res <= w_spec_res;
        end
        S_ITER: begin
          r_q   <= {r_q[WIDTH-2:0], w_sub_ok};
          r_r   <= w_sub_ok ? w_trial[WIDTH-1:0]
                            : {r_r[WIDTH-2:0], r_q[WIDTH-1]};
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX:  r_res <= w_fix;
        default: ;
      endcase
    end
  end

  assign bus.BusyE      = (r_state != S_IDLE);
  assign bus.DoneE      = (r_state == S_DONE);
  assign bus.DivResultE = r_res;
endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, results,
// special cases, flush, ignored start and async reset.
module tb_div_unit;
  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_fail;
  logic [31:0] last_res;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(string tag, logic [1:0] op,
                        logic [31:0] a, logic [31:0] b,
                        logic [31:0] exp, int lat, bit poke);
    int done_at;
    int busy_bad;
    int hold_bad;
    done_at  = 0;
    busy_bad = 0;
    hold_bad = 0;
    bus.StartE = 1'b1;
    bus.DivOpE = op;
    bus.Op1E   = a;
    bus.Op2E   = b;
    step();
    bus.StartE = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.DoneE) begin
        done_at = c;
        break;
      end
      if (!bus.BusyE) busy_bad++;
      if (bus.DivResultE !== last_res) hold_bad++;
      if (poke && c == 5) begin
        bus.StartE = 1'b1;
        bus.DivOpE = DIVU;
        bus.Op1E   = 32'd9;
        bus.Op2E   = 32'd3;
      end else if (poke && c == 6) begin
        bus.StartE = 1'b0;
      end
      step();
    end
    bus.StartE = 1'b0;
    chk({tag, "_lat"}, done_at, lat);
    chk({tag, "_busy"}, busy_bad, 0);
    chk({tag, "_hold"}, hold_bad, 0);
    chk({tag, "_busydone"}, {31'b0, bus.BusyE}, 1);
    chk({tag, "_res"}, bus.DivResultE, exp);
    last_res = exp;
    step();
    chk({tag, "_idle"}, {30'b0, bus.BusyE, bus.DoneE}, 0);
    chk({tag, "_keep"}, bus.DivResultE, exp);
  endtask

  initial begin
    int bad;
    n_chk      = 0;
    n_fail     = 0;
    last_res   = '0;
    reset_n    = 1'b0;
    bus.StartE = 1'b0;
    bus.DivOpE = DIV;
    bus.Op1E   = '0;
    bus.Op2E   = '0;
    bus.FlushE = 1'b0;
    step();
    step();
    chk("rst_busy", {31'b0, bus.BusyE}, 0);
    chk("rst_done", {31'b0, bus.DoneE}, 0);
    chk("rst_res", bus.DivResultE, 0);
    reset_n = 1'b1;
    step();

    run_op("div_100_7", DIV, 32'd100, 32'd7, 32'd14, 34, 0);
    run_op("rem_100_7", REM, 32'd100, 32'd7, 32'd2, 34, 0);
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
    run_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
    run_op("divu_m7_2", DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34, 0);
    run_op("remu_m7_2", REMU, 32'hFFFF_FFF9, 32'd2, 32'd1, 34, 0);
    run_op("divu_z", DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("rem_z", REM, 32'h1234, 32'd0, 32'h1234, 1, 0);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    run_op("divu_ovf", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 0);
    run_op("div_poke", DIV, 32'd100, 32'd7, 32'd14, 34, 1);

    // Flush at cycle T+10, restart at T+11.
    bad = 0;
    bus.StartE = 1'b1;
    bus.DivOpE = DIVU;
    bus.Op1E   = 32'd100;
    bus.Op2E   = 32'd7;
    step();
    bus.StartE = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (bus.DoneE || !bus.BusyE) bad++;
      step();
    end
    bus.FlushE = 1'b1;
    step();
    bus.FlushE = 1'b0;
    chk("flush_pre", bad, 0);
    chk("flush_busy", {31'b0, bus.BusyE}, 0);
    chk("flush_done", {31'b0, bus.DoneE}, 0);
    chk("flush_res", bus.DivResultE, last_res);
    run_op("flush_restart", DIVU, 32'd9, 32'd3, 32'd3, 34, 0);

    // Asynchronous reset mid-iteration.
    bus.StartE = 1'b1;
    bus.DivOpE = DIV;
    bus.Op1E   = 32'd100;
    bus.Op2E   = 32'd7;
    step();
    bus.StartE = 1'b0;
    repeat (8) step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, bus.BusyE}, 0);
    chk("arst_done", {31'b0, bus.DoneE}, 0);
    chk("arst_res", bus.DivResultE, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("arst_idle", {31'b0, bus.BusyE}, 0);
    last_res = '0;
    run_op("post_rst", DIV, 32'd100, 32'd7, 32'd14, 34, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
